// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: fetch/decode/sequence over a req/ack memory port.
// Optional macro CPU_CTRL_BRZ_EN makes JUMP with ir[DW-4]=1 conditional on flag_zero.
//
// state  | meaning
// START  | idle, wait for run
// FETCH  | read instruction word at pc
// DECODE | one-cycle decode of ir
// OPER   | read operand word at pc (LOAD/STORE/JUMP)
// ALU    | one-cycle register write from the ALU
// MEM    | data access at operand address
// HALT   | STOP executed, only rst leaves
module cpu_ctrl #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int NREG = 4,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    alu_op,
    input  logic          alu_zero,
    output logic [RW-1:0] rf_sel,
    output logic          rf_we,
    output logic          wb_src,
    output logic [AW-1:0] pc,
    output logic          flag_zero,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_OPER, S_ALU, S_MEM, S_HALT
    } state_t;

    localparam logic [2:0] OP_MATH  = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_STOP  = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    state_t        state;
    logic [DW-1:0] ir;
    logic [DW-1:0] opnd;
    logic          rf_we_alu;

    logic [2:0]    opcode;
    logic [1:0]    sub_op;
    logic [RW-1:0] rd;
    logic [AW-1:0] pc_inc;
    logic          jump_taken;
    logic          unused_bits;

    assign opcode = ir[DW-1 -: 3];
    assign sub_op = ir[DW-4 -: 2];
    assign rd     = ir[RW-1:0];
    assign pc_inc = pc + AW'(1);

`ifdef CPU_CTRL_BRZ_EN
    assign jump_taken = ~ir[DW-4] | flag_zero;
`else
    assign jump_taken = 1'b1;
`endif

    // Operand bits beyond the address and ir bits outside the decoded fields.
    assign unused_bits = ^{opnd, ir};

    // The LOAD write strobe must coincide with the data, so it follows mem_ack
    // directly; reset in the same cycle suppresses any register-file write.
    assign rf_we = ~rst & (rf_we_alu |
                   ((state == S_MEM) && (opcode == OP_LOAD) && mem_ack));

    function automatic logic [2:0] alu_code(input logic [2:0] op, input logic [1:0] sub);
        case (op)
            OP_MATH: alu_code = {1'b0, sub};
            OP_XOR:  alu_code = 3'd4;
            OP_OR:   alu_code = 3'd5;
            OP_AND:  alu_code = 3'd6;
            default: alu_code = 3'd0;
        endcase
    endfunction

    // Outputs are loaded on the transition into the state that needs them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_START;
            pc        <= '0;
            ir        <= '0;
            opnd      <= '0;
            flag_zero <= 1'b0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            alu_op    <= '0;
            rf_sel    <= '0;
            rf_we_alu <= 1'b0;
            wb_src    <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    if (run) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc_inc;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_STOP: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        OP_LOAD, OP_STORE, OP_JUMP: begin
                            state    <= S_OPER;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end
                        default: begin
                            state     <= S_ALU;
                            rf_we_alu <= 1'b1;
                            rf_sel    <= rd;
                            alu_op    <= alu_code(opcode, sub_op);
                        end
                    endcase
                end
                S_ALU: begin
                    flag_zero <= alu_zero;
                    rf_we_alu <= 1'b0;
                    rf_sel    <= '0;
                    alu_op    <= '0;
                    state     <= S_FETCH;
                    mem_req   <= 1'b1;
                    mem_addr  <= pc;
                end
                S_OPER: begin
                    if (mem_ack) begin
                        opnd <= mem_rdata;
                        if (opcode == OP_JUMP) begin
                            state <= S_FETCH;
                            if (jump_taken) begin
                                pc       <= mem_rdata[AW-1:0];
                                mem_addr <= mem_rdata[AW-1:0];
                            end else begin
                                pc       <= pc_inc;
                                mem_addr <= pc_inc;
                            end
                        end else begin
                            pc       <= pc_inc;
                            state    <= S_MEM;
                            mem_addr <= mem_rdata[AW-1:0];
                            mem_we   <= (opcode == OP_STORE);
                            rf_sel   <= rd;
                            wb_src   <= (opcode == OP_LOAD);
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (opcode == OP_LOAD) begin
                            flag_zero <= (mem_rdata == '0);
                        end
                        state    <= S_FETCH;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        rf_sel   <= '0;
                        wb_src   <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state   <= S_START;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a wait-state memory model; expectations are hand-computed.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [2:0] alu_op;
    logic       alu_zero = 1'b0;
    logic [1:0] rf_sel;
    logic       rf_we, wb_src;
    logic [7:0] pc;
    logic       flag_zero, halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:255];
    int         wait_n   = 0;
    int         wcnt     = 0;
    logic       mem_auto = 1'b1;
    logic       man_ack  = 1'b0;
    logic [7:0] man_rdata = 8'h00;

    cpu_ctrl #(.DW(8), .AW(8), .NREG(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_zero(alu_zero),
        .rf_sel(rf_sel), .rf_we(rf_we), .wb_src(wb_src),
        .pc(pc), .flag_zero(flag_zero), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory answers at the falling edge so ack/data are settled before the next rising edge.
    always @(negedge clk) begin
        if (!mem_auto) begin
            mem_ack   = man_ack;
            mem_rdata = man_rdata;
        end else if (mem_req) begin
            if (wcnt == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
    endtask

    // Leaves the bench in cycle 0 (START) with run=1; the next tick lands in the first FETCH.
    task automatic start_cpu(input int wn);
        wait_n   = wn;
        mem_auto = 1'b1;
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_we, rf_we, wb_src, halted, flag_zero} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, mem_we, rf_we, wb_src, halted, flag_zero});
            n_fail++;
        end
        n_tests++;
        if (pc !== 8'h00) begin
            $display("FAIL reset_pc: got %h expected 00", pc);
            n_fail++;
        end
        n_tests++;
        if ({mem_addr, alu_op, rf_sel} !== 13'b0) begin
            $display("FAIL reset_sel: got %h expected 0", {mem_addr, alu_op, rf_sel});
            n_fail++;
        end
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (mem_req !== 1'b0) begin
            $display("FAIL start_idle: mem_req got %b expected 0", mem_req);
            n_fail++;
        end
    endtask

    task automatic test_xor();
        clear_mem();
        mem[0] = 8'h21;
        alu_zero = 1'b1;
        start_cpu(0);
        tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            $display("FAIL xor_fetch: req/addr got %b/%h expected 1/00", mem_req, mem_addr);
            n_fail++;
        end
        tick();
        n_tests++;
        if (pc !== 8'h01 || mem_req !== 1'b0) begin
            $display("FAIL xor_decode: pc/req got %h/%b expected 01/0", pc, mem_req);
            n_fail++;
        end
        tick();
        n_tests++;
        if (alu_op !== 3'd4 || rf_sel !== 2'd1 || rf_we !== 1'b1 || wb_src !== 1'b0) begin
            $display("FAIL xor_alu: op/sel/we/src got %0d/%0d/%b/%b expected 4/1/1/0", alu_op, rf_sel, rf_we, wb_src);
            n_fail++;
        end
        tick();
        n_tests++;
        if (flag_zero !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 8'h01 || rf_we !== 1'b0) begin
            $display("FAIL xor_refetch: z/req/addr/we got %b/%b/%h/%b expected 1/1/01/0", flag_zero, mem_req, mem_addr, rf_we);
            n_fail++;
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [7:0] prog [6];
        logic [2:0] ops  [6];
        logic [1:0] rds  [6];
        logic       exp_z;
        prog = '{8'h00, 8'h09, 8'h12, 8'h1B, 8'h40, 8'h61};
        ops  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        rds  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_z = 1'b0;
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = prog[i];
        start_cpu(0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) run = 1'b0;
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 8'(i) || flag_zero !== exp_z) begin
                $display("FAIL ops_fetch%0d: req/addr/z got %b/%h/%b expected 1/%h/%b", i, mem_req, mem_addr, flag_zero, 8'(i), exp_z);
                n_fail++;
            end
            tick();
            tick();
            n_tests++;
            if (alu_op !== ops[i] || rf_sel !== rds[i] || rf_we !== 1'b1) begin
                $display("FAIL ops_alu%0d: op/sel/we got %0d/%0d/%b expected %0d/%0d/1", i, alu_op, rf_sel, rf_we, ops[i], rds[i]);
                n_fail++;
            end
            exp_z = ((i % 2) == 0);
            alu_zero = exp_z;
        end
        tick();
        n_tests++;
        if (flag_zero !== exp_z || mem_addr !== 8'h06) begin
            $display("FAIL ops_last: z/addr got %b/%h expected %b/06", flag_zero, mem_addr, exp_z);
            n_fail++;
        end
        run = 1'b1;
        alu_zero = 1'b0;
    endtask

    task automatic test_load_wait();
        int bad;
        clear_mem();
        mem[0] = 8'hA2;
        mem[1] = 8'h40;
        mem[8'h40] = 8'h00;
        start_cpu(2);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 8'h00 || rf_we !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL load_fetch_hold: bad cycles got %0d expected 0", bad);
            n_fail++;
        end
        tick();
        n_tests++;
        if (mem_req !== 1'b0 || pc !== 8'h01) begin
            $display("FAIL load_decode: req/pc got %b/%h expected 0/01", mem_req, pc);
            n_fail++;
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 8'h01 || mem_we !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL load_oper_hold: bad cycles got %0d expected 0", bad);
            n_fail++;
        end
        bad = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 8'h40 || rf_we !== 1'b0 || mem_we !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL load_mem_wait: bad cycles got %0d expected 0", bad);
            n_fail++;
        end
        tick();
        n_tests++;
        if (rf_we !== 1'b1 || wb_src !== 1'b1 || rf_sel !== 2'd2 || mem_addr !== 8'h40) begin
            $display("FAIL load_wb: we/src/sel/addr got %b/%b/%0d/%h expected 1/1/2/40", rf_we, wb_src, rf_sel, mem_addr);
            n_fail++;
        end
        tick();
        n_tests++;
        if (flag_zero !== 1'b1 || pc !== 8'h02 || mem_addr !== 8'h02 || rf_we !== 1'b0) begin
            $display("FAIL load_done: z/pc/addr/we got %b/%h/%h/%b expected 1/02/02/0", flag_zero, pc, mem_addr, rf_we);
            n_fail++;
        end
    endtask

    task automatic test_store();
        clear_mem();
        mem[0] = 8'h21;
        mem[1] = 8'hC3;
        mem[2] = 8'h80;
        mem[8'h80] = 8'h55;
        alu_zero = 1'b1;
        start_cpu(0);
        repeat (5) tick();
        alu_zero = 1'b0;
        tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h02 || mem_we !== 1'b0) begin
            $display("FAIL store_oper: req/addr/we got %b/%h/%b expected 1/02/0", mem_req, mem_addr, mem_we);
            n_fail++;
        end
        tick();
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h80 || rf_we !== 1'b0 || rf_sel !== 2'd3 || mem_req !== 1'b1) begin
            $display("FAIL store_mem: we/addr/rfwe/sel/req got %b/%h/%b/%0d/%b expected 1/80/0/3/1", mem_we, mem_addr, rf_we, rf_sel, mem_req);
            n_fail++;
        end
        tick();
        n_tests++;
        if (flag_zero !== 1'b1 || pc !== 8'h03 || mem_addr !== 8'h03 || mem_we !== 1'b0) begin
            $display("FAIL store_done: z/pc/addr/we got %b/%h/%h/%b expected 1/03/03/0", flag_zero, pc, mem_addr, mem_we);
            n_fail++;
        end
    endtask

    task automatic test_jump();
        logic [7:0] exp_cond;
        clear_mem();
        mem[0] = 8'hE0;
        mem[1] = 8'h10;
        start_cpu(0);
        repeat (4) tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10 || pc !== 8'h10) begin
            $display("FAIL jump_taken: req/addr/pc got %b/%h/%h expected 1/10/10", mem_req, mem_addr, pc);
            n_fail++;
        end
`ifdef CPU_CTRL_BRZ_EN
        exp_cond = 8'h02;
`else
        exp_cond = 8'h10;
`endif
        mem[0] = 8'hF0;
        start_cpu(0);
        repeat (4) tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== exp_cond || pc !== exp_cond) begin
            $display("FAIL jump_cond: req/addr/pc got %b/%h/%h expected 1/%h/%h", mem_req, mem_addr, pc, exp_cond, exp_cond);
            n_fail++;
        end
    endtask

    task automatic test_stop_halt();
        int bad;
        clear_mem();
        mem[0] = 8'h80;
        start_cpu(0);
        tick();
        tick();
        n_tests++;
        if (halted !== 1'b0) begin
            $display("FAIL stop_early: halted got %b expected 0", halted);
            n_fail++;
        end
        tick();
        n_tests++;
        if (halted !== 1'b1 || mem_req !== 1'b0) begin
            $display("FAIL stop_halt: halted/req got %b/%b expected 1/0", halted, mem_req);
            n_fail++;
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_req !== 1'b0 || halted !== 1'b1 || rf_we !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL halt_hold: bad cycles got %0d expected 0", bad);
            n_fail++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (halted !== 1'b0 || pc !== 8'h00) begin
            $display("FAIL halt_reset: halted/pc got %b/%h expected 0/00", halted, pc);
            n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_ack();
        clear_mem();
        start_cpu(0);
        mem_auto  = 1'b0;
        man_ack   = 1'b0;
        man_rdata = 8'h21;
        tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_ack !== 1'b0) begin
            $display("FAIL rstack_wait: req/ack got %b/%b expected 1/0", mem_req, mem_ack);
            n_fail++;
        end
        man_ack = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (rf_we !== 1'b0 || mem_ack !== 1'b1) begin
            $display("FAIL rstack_we: rf_we/ack got %b/%b expected 0/1", rf_we, mem_ack);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || rf_we !== 1'b0) begin
            $display("FAIL rstack_state: req/pc/we got %b/%h/%b expected 0/00/0", mem_req, pc, rf_we);
            n_fail++;
        end
        man_ack = 1'b0;
        rst = 1'b0;
        run = 1'b0;
        tick();
        tick();
        n_tests++;
        if (mem_req !== 1'b0 || pc !== 8'h00) begin
            $display("FAIL rstack_start: req/pc got %b/%h expected 0/00", mem_req, pc);
            n_fail++;
        end
        mem_auto = 1'b1;
        run = 1'b1;
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[0] = 8'hE0;
        mem[1] = 8'hFF;
        mem[8'hFF] = 8'h21;
        mem[0] = 8'hE0;
        start_cpu(0);
        repeat (4) tick();
        n_tests++;
        if (mem_addr !== 8'hFF || mem_req !== 1'b1) begin
            $display("FAIL wrap_fetch: addr/req got %h/%b expected ff/1", mem_addr, mem_req);
            n_fail++;
        end
        tick();
        n_tests++;
        if (pc !== 8'h00) begin
            $display("FAIL wrap_pc: pc got %h expected 00", pc);
            n_fail++;
        end
        tick();
        tick();
        n_tests++;
        if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin
            $display("FAIL wrap_refetch: addr/req got %h/%b expected 00/1", mem_addr, mem_req);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_alu_ops();
        test_load_wait();
        test_store();
        test_jump();
        test_stop_halt();
        test_reset_ack();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
